// File: rtl/data_bus_resp_pkg.sv
// Shared constants for the data-bus responder: MMIO decode nibble, register
// offsets, reset values and bus widths.
package data_bus_resp_pkg;

  localparam int DataBus     = 32;
  localparam int DataAddrBus = 32;

  localparam logic [3:0] MmioBase = 4'h1;

  typedef enum logic [1:0] {
    BeepDivOff  = 2'd0,
    TimerCntOff = 2'd1,
    TimerCmpOff = 2'd2,
    StatusOff   = 2'd3
  } mmio_off_e;

  localparam logic [DataBus-1:0] TimerCmpRst = 32'hFFFF_FFFF;

  function automatic logic is_mmio(input logic [DataAddrBus-1:0] addr);
    return addr[31:28] == MmioBase;
  endfunction

endpackage

// File: rtl/data_bus_resp_beep_gen.sv
// Beeper tone generator: divider counter plus toggle flop. beem toggles every
// div clocks; div of 0 silences the output.
module beep_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        div_wr,
  output logic        beem
);

  logic [15:0] div_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      beem        <= 1'b0;
    end else if (div == 16'd0) begin
      div_cnt_reg <= '0;
      beem        <= 1'b0;
    end else if (div_wr) begin
      // A new divisor restarts the half-period but keeps the current level.
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == div - 16'd1) begin
      div_cnt_reg <= '0;
      beem        <= ~beem;
    end else begin
      div_cnt_reg <= div_cnt_reg + 16'd1;
    end
  end

endmodule

// File: rtl/data_bus_resp.sv
// CPU data-bus responder: word RAM with byte lanes plus a small MMIO window
// (beeper, optional timer enabled by DATA_BUS_RESP_TIMER_EN).
module data_bus_resp
  import data_bus_resp_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_ce_i,
  input  logic                   ram_we_i,
  input  logic [3:0]             ram_sel_i,
  input  logic [DataAddrBus-1:0] ram_addr_i,
  input  logic [DataBus-1:0]     ram_data_i,
  output logic [DataBus-1:0]     ram_data_o,
  output logic                   beem_o
);

  logic              mmio_sel;
  mmio_off_e         mmio_off;
  logic [ADDR_W-1:0] word_idx;
  logic              ram_wr;
  logic              mmio_wr;
  logic              div_wr;
  logic [DataBus-1:0] lane_mask;
  logic [DataBus-1:0] ram_rd_word;
  logic [DataBus-1:0] mmio_rd_word;
  logic [15:0]        beep_div_reg;
  logic               unused_addr_bits;

  assign mmio_sel = is_mmio(ram_addr_i);
  assign mmio_off = mmio_off_e'(ram_addr_i[3:2]);
  assign word_idx = ram_addr_i[ADDR_W+1:2];
  assign ram_wr   = ram_ce_i & ram_we_i & ~mmio_sel;
  assign mmio_wr  = ram_ce_i & ram_we_i & mmio_sel;
  assign div_wr   = mmio_wr & (mmio_off == BeepDivOff);

  // Upper RAM address bits alias and the byte offset is the core's concern.
  assign unused_addr_bits = ^{ram_addr_i[27:ADDR_W+2], ram_addr_i[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{ram_sel_i[gi]}};
    end
  endgenerate

  logic [DataBus-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[word_idx] <= (mem[word_idx] & ~lane_mask) | (ram_data_i & lane_mask);
    end
  end

  assign ram_rd_word = mem[word_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beep_div_reg <= '0;
    end else if (div_wr) begin
      beep_div_reg <= ram_data_i[15:0];
    end
  end

  beep_gen u_beep_gen (
    .clk    (clk),
    .rst    (rst),
    .div    (beep_div_reg),
    .div_wr (div_wr),
    .beem   (beem_o)
  );

`ifdef DATA_BUS_RESP_TIMER_EN
  logic [DataBus-1:0] timer_cnt_reg;
  logic [DataBus-1:0] timer_cmp_reg;
  logic               match_flag_reg;
  logic               match_flag_next;
  logic               status_clr;

  assign status_clr = mmio_wr & (mmio_off == StatusOff) & ram_data_i[0];

  // A match in the same cycle as a clear still leaves the flag set.
  assign match_flag_next = (timer_cnt_reg == timer_cmp_reg) |
                           (match_flag_reg & ~status_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_cnt_reg  <= '0;
      timer_cmp_reg  <= TimerCmpRst;
      match_flag_reg <= 1'b0;
    end else begin
      match_flag_reg <= match_flag_next;
      if (mmio_wr && mmio_off == TimerCntOff) begin
        timer_cnt_reg <= ram_data_i;
      end else begin
        timer_cnt_reg <= timer_cnt_reg + 32'd1;
      end
      if (mmio_wr && mmio_off == TimerCmpOff) begin
        timer_cmp_reg <= ram_data_i;
      end
    end
  end
`endif

  always_comb begin
    mmio_rd_word = '0;
    case (mmio_off)
      BeepDivOff:  mmio_rd_word = {16'h0000, beep_div_reg};
`ifdef DATA_BUS_RESP_TIMER_EN
      TimerCntOff: mmio_rd_word = timer_cnt_reg;
      TimerCmpOff: mmio_rd_word = timer_cmp_reg;
      StatusOff:   mmio_rd_word = {31'b0, match_flag_reg};
`endif
      default:     mmio_rd_word = '0;
    endcase
  end

  always_comb begin
    ram_data_o = '0;
    if (ram_ce_i) begin
      ram_data_o = mmio_sel ? mmio_rd_word : ram_rd_word;
    end
  end

endmodule

// File: tb/tb_data_bus_resp.sv
// Bench for data_bus_resp: directed literal checks plus randomized traffic
// compared every cycle against a register-level behavioural model.
module tb_data_bus_resp;

`ifdef DATA_BUS_RESP_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  localparam logic [31:0] A_DIV  = 32'h1000_0000;
  localparam logic [31:0] A_CNT  = 32'h1000_0004;
  localparam logic [31:0] A_CMP  = 32'h1000_0008;
  localparam logic [31:0] A_STAT = 32'h1000_000C;

  logic        clk;
  logic        rst;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        beem_o;

  int total;
  int bad;

  data_bus_resp #(.ADDR_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .ram_ce_i   (ram_ce_i),
    .ram_we_i   (ram_we_i),
    .ram_sel_i  (ram_sel_i),
    .ram_addr_i (ram_addr_i),
    .ram_data_i (ram_data_i),
    .ram_data_o (ram_data_o),
    .beem_o     (beem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural registers only.
  logic [31:0] m_mem   [512];
  logic [3:0]  m_known [512];
  logic [15:0] m_div;
  int          m_bcnt;
  logic        m_beem;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_flag;

  task model_reset();
    m_div  = 16'd0;
    m_bcnt = 0;
    m_beem = 1'b0;
    m_cnt  = 32'd0;
    m_cmp  = 32'hFFFF_FFFF;
    m_flag = 1'b0;
  endtask

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[31:28] == 4'h1) begin
      case (a[3:2])
        2'd0: r = {16'd0, m_div};
        2'd1: r = TIMER ? m_cnt : 32'd0;
        2'd2: r = TIMER ? m_cmp : 32'd0;
        default: r = TIMER ? {31'd0, m_flag} : 32'd0;
      endcase
    end else begin
      r = m_mem[a[10:2]];
    end
    return r;
  endfunction

  function automatic logic [31:0] known_mask(input logic [31:0] a);
    logic [31:0] k;
    k = 32'hFFFF_FFFF;
    if (a[31:28] != 4'h1) begin
      for (int l = 0; l < 4; l++) k[8*l +: 8] = {8{m_known[a[10:2]][l]}};
    end
    return k;
  endfunction

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    logic wr, mm;
    logic [1:0] off;
    logic [31:0] nxt_cnt;
    logic nxt_flag;
    if (rst) begin
      wr  = ram_ce_i & ram_we_i;
      mm  = ram_addr_i[31:28] == 4'h1;
      off = ram_addr_i[3:2];
      if (wr && !mm) begin
        for (int l = 0; l < 4; l++) begin
          if (ram_sel_i[l]) begin
            m_mem[ram_addr_i[10:2]][8*l +: 8] = ram_data_i[8*l +: 8];
            m_known[ram_addr_i[10:2]][l] = 1'b1;
          end
        end
      end
      if (m_div == 16'd0) begin
        m_bcnt = 0;
        m_beem = 1'b0;
      end else if (wr && mm && off == 2'd0) begin
        m_bcnt = 0;
      end else if (m_bcnt + 1 >= int'(m_div)) begin
        m_bcnt = 0;
        m_beem = ~m_beem;
      end else begin
        m_bcnt++;
      end
      if (wr && mm && off == 2'd0) m_div = ram_data_i[15:0];
      nxt_flag = (m_cnt == m_cmp) || (m_flag && !(wr && mm && off == 2'd3 && ram_data_i[0]));
      nxt_cnt  = (wr && mm && off == 2'd1) ? ram_data_i : m_cnt + 32'd1;
      if (wr && mm && off == 2'd2) m_cmp = ram_data_i;
      m_cnt  = nxt_cnt;
      m_flag = nxt_flag;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] k;
    if (rst) begin
      if (!ram_ce_i) begin
        check("rd_idle", ram_data_o, 32'd0);
      end else begin
        k = known_mask(ram_addr_i);
        if (k != 32'd0) check("rd_model", ram_data_o & k, exp_rd(ram_addr_i) & k);
      end
      check("beem_model", {31'd0, beem_o}, {31'd0, m_beem});
    end
  end

  task wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = s; ram_addr_i = a; ram_data_i = d;
    @(posedge clk); #1;
    ram_ce_i = 1'b0; ram_we_i = 1'b0;
    $display("wr   addr=%h data=%h sel=%b", a, d, s);
  endtask

  task rd(input logic [31:0] a, output logic [31:0] d);
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = a;
    #1;
    d = ram_data_o;
    $display("rd   addr=%h data=%h", a, d);
  endtask

  task idle(input int n);
    ram_ce_i = 1'b0; ram_we_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    int sel_off;
    total = 0; bad = 0;
    for (int i = 0; i < 512; i++) m_known[i] = 4'h0;
    model_reset();
    rst = 1'b0; ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_sel_i = 4'h0;
    ram_addr_i = 32'd0; ram_data_i = 32'd0;
    #1;
    check("reset_rd_idle", ram_data_o, 32'd0);
    check("reset_beem", {31'd0, beem_o}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    idle(1);
    rd(A_DIV, d);  check("reset_div", d, 32'd0);
    rd(A_CMP, d);  check("reset_cmp", d, TIMER ? 32'hFFFF_FFFF : 32'd0);
    rd(A_STAT, d); check("reset_flag", d, 32'd0);

    // RAM word write, aliasing, ce gating.
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    rd(32'h0000_0010, d); check("word_rd", d, 32'hDEAD_BEEF);
    rd(32'h0000_0813, d); check("alias_rd", d, 32'hDEAD_BEEF);
    ram_ce_i = 1'b0; #1;
    check("ce_off_zero", ram_data_o, 32'd0);
    wr(32'h0000_0020, 32'h1122_3344, 4'hF);
    wr(32'h0000_0020, 32'hAABB_CCDD, 4'b0100);
    rd(32'h0000_0020, d); check("lane_merge", d, 32'h11BB_3344);
    // Old word is visible during the write cycle.
    ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = 4'hF; ram_data_i = 32'h0;
    #1; check("rd_during_wr", ram_data_o, 32'h11BB_3344);
    @(posedge clk); #1;
    ram_we_i = 1'b0; #1; check("rd_after_wr", ram_data_o, 32'h0);

    // Beeper: divide by 3, then silence.
    wr(A_DIV, 32'hFFFF_0003, 4'h0);
    rd(A_DIV, d); check("div_rd", d, 32'h0000_0003);
    idle(2); check("beep_t2", {31'd0, beem_o}, 32'd0);
    idle(1); check("beep_t3", {31'd0, beem_o}, 32'd1);
    idle(3); check("beep_t6", {31'd0, beem_o}, 32'd0);
    idle(3); check("beep_t9", {31'd0, beem_o}, 32'd1);
    wr(A_DIV, 32'd0, 4'hF);
    check("beep_keep_level", {31'd0, beem_o}, 32'd1);
    idle(1); check("beep_off", {31'd0, beem_o}, 32'd0);
    idle(10); check("beep_stays_off", {31'd0, beem_o}, 32'd0);

    if (TIMER) begin
      wr(A_CMP, 32'd10, 4'hF);
      wr(A_STAT, 32'd1, 4'hF);
      wr(A_CNT, 32'd5, 4'hF);
      rd(A_CNT, d);  check("cnt_load", d, 32'd5);
      rd(A_STAT, d); check("flag_t0", d, 32'd0);
      idle(5);
      rd(A_CNT, d);  check("cnt_t5", d, 32'd10);
      rd(A_STAT, d); check("flag_t5", d, 32'd0);
      idle(1);
      rd(A_STAT, d); check("flag_t6", d, 32'd1);
      wr(A_STAT, 32'd1, 4'h0);
      rd(A_STAT, d); check("flag_clr", d, 32'd0);
      idle(1);
      rd(A_STAT, d); check("flag_stays_clr", d, 32'd0);
      wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
      rd(A_CNT, d);  check("wrap_t0", d, 32'hFFFF_FFFE);
      idle(1);
      rd(A_CNT, d);  check("wrap_t1", d, 32'hFFFF_FFFF);
      idle(1);
      rd(A_CNT, d);  check("wrap_t2", d, 32'd0);
    end else begin
      rd(A_CNT, d);  check("noimpl_cnt", d, 32'd0);
      wr(A_CMP, 32'h0000_1234, 4'hF);
      rd(A_CMP, d);  check("noimpl_cmp", d, 32'd0);
      rd(A_STAT, d); check("noimpl_stat", d, 32'd0);
    end

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 1500; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a[31:28] = 4'h1;
        sel_off = int'(a[3:2]);
      end else begin
        a[10:2] = 9'($urandom_range(0, 31));
        if (a[31:28] == 4'h1) a[31:28] = 4'h0;
        sel_off = -1;
      end
      ram_ce_i   = ($urandom_range(0, 4) != 0);
      ram_we_i   = $urandom_range(0, 1) == 1;
      ram_sel_i  = 4'($urandom_range(0, 15));
      ram_addr_i = a;
      ram_data_i = $urandom;
      if (sel_off == 0) ram_data_i = $urandom_range(0, 6);
      if (sel_off == 2) ram_data_i = m_cnt + 32'($urandom_range(2, 20));
      $display("rnd  ce=%b we=%b addr=%h data=%h sel=%b", ram_ce_i, ram_we_i, a, ram_data_i, ram_sel_i);
      @(posedge clk); #1;
    end
    idle(1);

    // Asynchronous reset while the tone output is high.
    wr(A_DIV, 32'd3, 4'hF);
    begin : wait_hi
      for (int i = 0; i < 20; i++) begin
        if (beem_o === 1'b1) disable wait_hi;
        idle(1);
      end
    end
    check("reset_setup_beem", {31'd0, beem_o}, 32'd1);
    rst = 1'b0;
    #1; check("async_beem", {31'd0, beem_o}, 32'd0);
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = A_DIV;
    #1; check("async_div", ram_data_o, 32'd0);
    ram_addr_i = A_CMP;
    #1; check("async_cmp", ram_data_o, TIMER ? 32'hFFFF_FFFF : 32'd0);
    ram_ce_i = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    idle(1);
    rd(A_DIV, d);  check("post_reset_div", d, 32'd0);
    rd(A_CMP, d);  check("post_reset_cmp", d, TIMER ? 32'hFFFF_FFFF : 32'd0);
    rd(A_STAT, d); check("post_reset_flag", d, 32'd0);
    idle(3);
    check("post_reset_beem", {31'd0, beem_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
